// File: rtl/wb_pkg.sv
// Shared Wishbone widths, decoder FSM states and the default error read data.
package wb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        ERR
    } state_t;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational priority address matcher: finds the lowest-index slave whose
// masked base equals the masked address.
module wb_addr_match
    import wb_pkg::*;
#(
    parameter int                     NSLV     = 4,
    parameter int                     IDX_W    = (NSLV > 1) ? $clog2(NSLV) : 1,
    parameter logic [NSLV*ADR_W-1:0]  SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                  32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*ADR_W-1:0]  SLV_MASK = {4{32'hF000_0000}}
) (
    input  logic [ADR_W-1:0] adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the highest index down so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((adr & SLV_MASK[i*ADR_W +: ADR_W]) == SLV_BASE[i*ADR_W +: ADR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master to NSLV-slave Wishbone decoder with one cycle of decode
// latency, ack timeout, and error responses for unmapped or silent slaves.
module wb_bus_decoder
    import wb_pkg::*;
#(
    parameter int                     NSLV     = 4,
    parameter logic [NSLV*ADR_W-1:0]  SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                  32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*ADR_W-1:0]  SLV_MASK = {4{32'hF000_0000}},
    parameter int                     TIMEOUT  = 255,
    parameter logic [DAT_W-1:0]       ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADR_W-1:0]      wbs_adr_i,
    input  logic [DAT_W-1:0]      wbs_dat_i,
    input  logic                  wbs_we_i,
    input  logic [SEL_W-1:0]      wbs_sel_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    output logic [DAT_W-1:0]      wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic [ADR_W-1:0]      wbm_adr_o,
    output logic [DAT_W-1:0]      wbm_dat_o,
    output logic                  wbm_we_o,
    output logic [SEL_W-1:0]      wbm_sel_o,
    output logic [NSLV-1:0]       wbm_stb_o,
    output logic [NSLV-1:0]       wbm_cyc_o,
    input  logic [NSLV*DAT_W-1:0] wbm_dat_i,
    input  logic [NSLV-1:0]       wbm_ack_i,
    output logic [ADR_W-1:0]      err_adr_o,
    output logic                  err_stb_o
);

    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    state_t             state_q, state_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NSLV-1:0]    cyc_q, cyc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [DAT_W-1:0]   rdat_q, rdat_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [ADR_W-1:0]   err_adr_q, err_adr_d;
    logic               err_stb_q, err_stb_d;

    logic               match_hit;
    logic [IDX_W-1:0]   match_idx;

    wb_addr_match #(
        .NSLV     (NSLV),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_match (
        .adr (wbs_adr_i),
        .hit (match_hit),
        .idx (match_idx)
    );

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request, slave strobes, timeout counter and master response registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            cyc_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rdat_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
            err_stb_q <= 1'b0;
        end else begin
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rdat_q    <= rdat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
            err_stb_q <= err_stb_d;
        end
    end

    // Next-state and next-register logic; ack, err and err_stb are single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rdat_d    = rdat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        err_adr_d = err_adr_q;
        err_stb_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d = wbs_adr_i;
                    dat_d = wbs_dat_i;
                    we_d  = wbs_we_i;
                    // Reads arrive with sel=0, so slaves are shown all lanes enabled.
                    sel_d = wbs_we_i ? wbs_sel_i : {SEL_W{1'b1}};
                    if (match_hit) begin
                        cyc_d   = NSLV'(1) << match_idx;
                        idx_d   = match_idx;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end

            BUSY: begin
                if (!wbs_cyc_i) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                end else if (wbm_ack_i[idx_q]) begin
                    // An ack in the timeout cycle still wins because it is tested first.
                    cyc_d   = '0;
                    rdat_d  = wbm_dat_i[int'(idx_q)*DAT_W +: DAT_W];
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    cyc_d   = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ERR: begin
                ack_d     = 1'b1;
                err_d     = 1'b1;
                rdat_d    = ERR_DATA;
                err_adr_d = adr_q;
                err_stb_d = 1'b1;
                state_d   = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                cyc_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign wbs_dat_o = rdat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign err_adr_o = err_adr_q;
    assign err_stb_o = err_stb_q;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed self-checking bench for wb_bus_decoder (TIMEOUT overridden to 8).
module tb_wb_bus_decoder;

    localparam int NSLV = 4;

    logic                 wb_clk_i;
    logic                 wb_rst_i;
    logic [31:0]          wbs_adr_i;
    logic [31:0]          wbs_dat_i;
    logic                 wbs_we_i;
    logic [3:0]           wbs_sel_i;
    logic                 wbs_stb_i;
    logic                 wbs_cyc_i;
    logic [31:0]          wbs_dat_o;
    logic                 wbs_ack_o;
    logic                 wbs_err_o;
    logic [31:0]          wbm_adr_o;
    logic [31:0]          wbm_dat_o;
    logic                 wbm_we_o;
    logic [3:0]           wbm_sel_o;
    logic [NSLV-1:0]      wbm_stb_o;
    logic [NSLV-1:0]      wbm_cyc_o;
    logic [NSLV*32-1:0]   wbm_dat_i;
    logic [NSLV-1:0]      wbm_ack_i;
    logic [31:0]          err_adr_o;
    logic                 err_stb_o;

    int checks;
    int failures;

    wb_bus_decoder #(
        .NSLV    (NSLV),
        .TIMEOUT (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .err_adr_o (err_adr_o),
        .err_stb_o (err_stb_o)
    );

    // 100 MHz clock.
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wbs_cyc_i = cyc;
        wbs_stb_i = stb;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
    endtask

    task automatic slaveDrive(input logic [NSLV-1:0] ack, input int idx, input logic [31:0] data);
        wbm_ack_i = ack;
        wbm_dat_i[idx*32 +: 32] = data;
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Never more than one slave cycle line may be active.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) checkOutput("onehot_cyc", 32'($countones(wbm_cyc_o) <= 1), 32'd1);
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stbCycles;
        checks   = 0;
        failures = 0;
        wb_rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        wbm_ack_i = '0;
        wbm_dat_i = '0;

        // Reset values.
        #3;
        checkOutput("rst_stb", 32'(wbm_stb_o), 32'h0);
        checkOutput("rst_sel", 32'(wbm_sel_o), 32'h0);
        checkOutput("rst_ack", 32'(wbs_ack_o), 32'h0);
        checkOutput("rst_err_adr", err_adr_o, 32'h0);
        tick();
        tick();
        wb_rst_i = 1'b0;
        tick();
        checkOutput("idle_ack", 32'(wbs_ack_o), 32'h0);

        // Read from slave 1, ack two cycles after strobe.
        $display("[TB] read slave 1");
        slaveDrive('0, 1, 32'h1234_5678);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0);
        tick();
        checkOutput("rd_stb", 32'(wbm_stb_o), 32'h2);
        checkOutput("rd_cyc", 32'(wbm_cyc_o), 32'h2);
        checkOutput("rd_sel", 32'(wbm_sel_o), 32'hF);
        checkOutput("rd_adr", wbm_adr_o, 32'h1000_0010);
        checkOutput("rd_we", 32'(wbm_we_o), 32'h0);
        tick();
        checkOutput("rd_noack_yet", 32'(wbs_ack_o), 32'h0);
        slaveDrive(4'b0010, 1, 32'h1234_5678);
        tick();
        checkOutput("rd_ack", 32'(wbs_ack_o), 32'h1);
        checkOutput("rd_err", 32'(wbs_err_o), 32'h0);
        checkOutput("rd_dat", wbs_dat_o, 32'h1234_5678);
        checkOutput("rd_stb_drop", 32'(wbm_stb_o), 32'h0);
        slaveDrive('0, 1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("rd_ack_clr", 32'(wbs_ack_o), 32'h0);
        checkOutput("rd_dat_hold", wbs_dat_o, 32'h1234_5678);

        // Write to slave 3, immediate ack.
        $display("[TB] write slave 3");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hA5A5_0000, 4'b0011);
        tick();
        checkOutput("wr_stb", 32'(wbm_stb_o), 32'h8);
        checkOutput("wr_we", 32'(wbm_we_o), 32'h1);
        checkOutput("wr_sel", 32'(wbm_sel_o), 32'h3);
        checkOutput("wr_dat", wbm_dat_o, 32'hA5A5_0000);
        checkOutput("wr_adr", wbm_adr_o, 32'h3000_0004);
        slaveDrive(4'b1000, 3, 32'h0);
        tick();
        checkOutput("wr_ack", 32'(wbs_ack_o), 32'h1);
        checkOutput("wr_err", 32'(wbs_err_o), 32'h0);
        checkOutput("wr_stb_drop", 32'(wbm_stb_o), 32'h0);
        slaveDrive('0, 3, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("wr_ack_clr", 32'(wbs_ack_o), 32'h0);

        // Unmapped read.
        $display("[TB] unmapped read");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
        tick();
        checkOutput("um_stb", 32'(wbm_stb_o), 32'h0);
        checkOutput("um_noack_yet", 32'(wbs_ack_o), 32'h0);
        tick();
        checkOutput("um_ack", 32'(wbs_ack_o), 32'h1);
        checkOutput("um_err", 32'(wbs_err_o), 32'h1);
        checkOutput("um_dat", wbs_dat_o, 32'hDEAD_BEEF);
        checkOutput("um_err_adr", err_adr_o, 32'h5000_0000);
        checkOutput("um_err_stb", 32'(err_stb_o), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("um_ack_clr", 32'(wbs_ack_o), 32'h0);
        checkOutput("um_err_clr", 32'(wbs_err_o), 32'h0);
        checkOutput("um_err_stb_clr", 32'(err_stb_o), 32'h0);
        checkOutput("um_err_adr_hold", err_adr_o, 32'h5000_0000);

        // Slave 2 never acks: timeout after 8 strobe cycles.
        $display("[TB] timeout slave 2");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'h0);
        tick();
        checkOutput("to_stb", 32'(wbm_stb_o), 32'h4);
        stbCycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (wbm_stb_o != 4'b0100) break;
            stbCycles++;
            tick();
        end
        checkOutput("to_stb_cycles", 32'(stbCycles), 32'd8);
        checkOutput("to_noack_err_state", 32'(wbs_ack_o), 32'h0);
        tick();
        checkOutput("to_ack", 32'(wbs_ack_o), 32'h1);
        checkOutput("to_err", 32'(wbs_err_o), 32'h1);
        checkOutput("to_dat", wbs_dat_o, 32'hDEAD_BEEF);
        checkOutput("to_err_adr", err_adr_o, 32'h2000_0000);
        checkOutput("to_err_stb", 32'(err_stb_o), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("to_ack_clr", 32'(wbs_ack_o), 32'h0);

        // Slave 0 access with a spurious ack from slave 2.
        $display("[TB] spurious ack");
        slaveDrive('0, 0, 32'hC0DE_0000);
        slaveDrive('0, 2, 32'h2222_2222);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        tick();
        checkOutput("sp_stb", 32'(wbm_stb_o), 32'h1);
        slaveDrive(4'b0100, 2, 32'h2222_2222);
        tick();
        checkOutput("sp_ignored_ack", 32'(wbs_ack_o), 32'h0);
        checkOutput("sp_ignored_stb", 32'(wbm_stb_o), 32'h1);
        slaveDrive(4'b0101, 0, 32'hC0DE_0000);
        tick();
        checkOutput("sp_ack", 32'(wbs_ack_o), 32'h1);
        checkOutput("sp_dat", wbs_dat_o, 32'hC0DE_0000);
        slaveDrive('0, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Master drops cyc while BUSY.
        $display("[TB] master abort");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
        tick();
        checkOutput("ab_stb", 32'(wbm_stb_o), 32'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("ab_stb_drop", 32'(wbm_stb_o), 32'h0);
        checkOutput("ab_noack", 32'(wbs_ack_o), 32'h0);
        checkOutput("ab_noerr", 32'(wbs_err_o), 32'h0);
        tick();
        checkOutput("ab_noack_later", 32'(wbs_ack_o), 32'h0);
        checkOutput("ab_dat_hold", wbs_dat_o, 32'hC0DE_0000);

        // Reset asserted mid-BUSY, then a fresh read.
        $display("[TB] reset mid-busy");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0);
        tick();
        checkOutput("mr_stb", 32'(wbm_stb_o), 32'h8);
        #2;
        wb_rst_i = 1'b1;
        #1;
        checkOutput("mr_stb_rst", 32'(wbm_stb_o), 32'h0);
        checkOutput("mr_cyc_rst", 32'(wbm_cyc_o), 32'h0);
        checkOutput("mr_adr_rst", wbm_adr_o, 32'h0);
        checkOutput("mr_dat_rst", wbs_dat_o, 32'h0);
        checkOutput("mr_err_adr_rst", err_adr_o, 32'h0);
        checkOutput("mr_ack_rst", 32'(wbs_ack_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        wb_rst_i = 1'b0;
        tick();
        checkOutput("mr_noack_after", 32'(wbs_ack_o), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
        tick();
        checkOutput("mr_fresh_stb", 32'(wbm_stb_o), 32'h1);
        slaveDrive(4'b0001, 0, 32'h0000_5A5A);
        tick();
        checkOutput("mr_fresh_ack", 32'(wbs_ack_o), 32'h1);
        checkOutput("mr_fresh_dat", wbs_dat_o, 32'h0000_5A5A);
        checkOutput("mr_fresh_err", 32'(wbs_err_o), 32'h0);
        slaveDrive('0, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("mr_fresh_ack_clr", 32'(wbs_ack_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
